serial_adder_fsm: RTL and testbench
===================================

Name: serial_adder_fsm

Overview:
- Bit-serial WIDTH-bit adder built around a single 1-bit full-adder cell plus a registered carry.
- Operands load in parallel on a start request and shift LSB-first through the cell, one bit per clock.
- The result is presented in parallel with a one-cycle done pulse.
- Sits directly downstream of the combinational full-adder cell: it consumes the cell's Sum/Carry each cycle and closes the carry loop through a flip-flop.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; synchronous, active-low.
- start  input  1  request to load operands; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on accepted start.
- b  input  WIDTH  operand B; captured on accepted start.
- cin  input  1  carry-in; captured on accepted start.
- busy  output  1  high in RUN and DONE states.
- done  output  1  single-cycle pulse; result registers valid from this cycle.
- sum  output  WIDTH  registered result; holds until next completion.
- cout  output  1  registered carry-out; holds until next completion.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - Shift registers, carry flop, bit counter, sum, cout, busy and done all 0.
  - Reset asserted mid-RUN aborts the operation; no done is produced.
- States:
  - IDLE: busy=0. start=1 moves to RUN and loads A_sr<=a, B_sr<=b, carry<=cin, cnt<=0, S_sr<=0.
  - RUN: busy=1, for exactly WIDTH cycles. Each cycle:
    - cell inputs = A_sr[0], B_sr[0], carry.
    - S_sr<={s_bit, S_sr[WIDTH-1:1]}; A_sr and B_sr logical right shift; carry<=c_bit; cnt<=cnt+1.
    - When cnt==WIDTH-1: go to DONE, and on the same edge load sum<={s_bit, S_sr[WIDTH-1:1]} and cout<=c_bit.
  - DONE: busy=1, done=1 for one cycle; unconditionally returns to IDLE.
- Latency: start accepted at edge N gives done high in the cycle following edge N+WIDTH. The next start can be accepted at edge N+WIDTH+2.
- start while in RUN or DONE is ignored; no queuing.
- a/b/cin may change freely after the accepting edge.
- Counter width is $clog2(WIDTH). cnt is not used outside RUN and needs no wrap handling beyond WIDTH-1.
- Arithmetic is unsigned: {cout,sum} == a + b + cin, modulo 2^(WIDTH+1).
- sum/cout change only on the RUN-to-DONE edge or on reset.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output ovf (1 bit): signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - Captured on the RUN-to-DONE edge together with sum. This needs the carry flop value at cnt==WIDTH-1.
  - Reset value 0; holds with sum.
- Undefined: no ovf port and no extra logic; remaining behaviour identical.

Decomposition:
- Shared header (serial_adder_defs.vh):
  - `define state encodings: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Default WIDTH value.
- Sub-module serial_fa_cell: purely combinational 1-bit full adder (a, b, cin -> s, c).
  - Instantiated once; the FSM, shift registers and carry flop stay in serial_adder_fsm.

Test Plan:
- WIDTH=8, a=8'h3C, b=8'h0F, cin=0, start pulse -> done exactly 9 cycles after the accepting edge; sum=8'h4B, cout=0; busy high 9 cycles.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start held high continuously with changing a/b -> only operands at the accepting edges are used; one done per WIDTH+2 cycles; results match captured values.
- Reset: rst_n=0 for one cycle at RUN bit 4 -> state IDLE, outputs 0, no done. Next start with a=8'h01, b=8'h01 -> sum=8'h02.
- Results hold: after done, toggle a/b without start for 20 cycles -> sum/cout unchanged, done stays 0.
- With SERIAL_ADDER_OVF_EN: 8'h7F+8'h01 gives ovf=1, sum=8'h80. 8'hFF+8'h01 gives ovf=0, cout=1. Build without the macro -> port absent, earlier tests pass unchanged.

Source files
------------

// File: rtl/serial_adder_fsm_pkg.sv
// Shared types and defaults for the bit-serial adder.
// Holds the FSM state encoding and the default operand width.
package serial_adder_fsm_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/serial_adder_fsm_fa_cell.sv
// serial_fa_cell: combinational 1-bit full adder.
// Ports: a, b, cin -> s (sum bit), c (carry out).
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ cin;
  assign c = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_fsm.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, registered carry.
// Ports: clk, rst_n (sync, active-low), start, a, b, cin in;
//   busy, done (1-cycle pulse), sum, cout out.
// Optional: define SERIAL_ADDER_OVF_EN to add the ovf output
//   (signed two's-complement overflow, captured with sum).
module serial_adder_fsm
  import serial_adder_fsm_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  // The LSB of the result shifter is always shifted out
  // unused, so only the upper WIDTH-1 bits are kept.
  logic [WIDTH-2:0] s_sr_q, s_sr_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic             s_bit;
  logic             c_bit;
  logic [WIDTH-1:0] s_next;

  serial_fa_cell u_cell (
    .a   (a_sr_q[0]),
    .b   (b_sr_q[0]),
    .cin (carry_q),
    .s   (s_bit),
    .c   (c_bit)
  );

  assign s_next = {s_bit, s_sr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    s_sr_d  = s_sr_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          s_sr_d  = '0;
        end
      end
      RUN: begin
        s_sr_d  = s_next[WIDTH-1:1];
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = c_bit;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH-1)) begin
          state_d = DONE;
          sum_d   = s_next;
          cout_d  = c_bit;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB here
          ovf_d   = carry_q ^ c_bit;
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_fsm.sv
// Self-checking bench for serial_adder_fsm (WIDTH=8).
// Tables, corner sequences and random ops vs. an arithmetic model.
module tb_serial_adder_fsm;

  localparam int W = 8;
  localparam int P = W + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int nvec = 0;
  int nerr = 0;

  serial_adder_fsm #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } op_t;

  vec_t tbl[8];
  op_t  pend[$];

  function automatic logic [W:0] ref_add(
    input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ref_ovf(
    input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    r = ref_add(x, y, c);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full operation from an idle DUT; returns one edge after done.
  task automatic do_op(input logic [W-1:0] av,
                       input logic [W-1:0] bv,
                       input logic ci,
                       input string tag);
    logic [W:0] r;
    int lat, bc;
    bit got;
    r = ref_add(av, bv, ci);
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    bc = busy ? 1 : 0;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0; got = 0;
    while (!got && lat < 3 * W) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bc++;
      if (done) got = 1;
    end
    chk({tag, " latency"}, lat, W);
    chk({tag, " sum"}, sum, r[W-1:0]);
    chk({tag, " cout"}, cout, r[W]);
    chk({tag, " busy cycles"}, bc, W + 1);
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, " ovf"}, ovf, ref_ovf(av, bv, ci));
`endif
    @(posedge clk); #1;
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " busy after"}, busy, 0);
  endtask

  initial begin
    logic [W-1:0] hs;
    logic         hc;
    logic [W:0]   r;
    bit           seen;

    tbl[0] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
    tbl[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

    rst_n = 1'b0; start = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
`ifdef SERIAL_ADDER_OVF_EN
    chk("reset ovf", ovf, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d const sum", i), sum, tbl[i].s);
      chk($sformatf("tbl%0d const cout", i), cout, tbl[i].co);
    end

`ifdef SERIAL_ADDER_OVF_EN
    do_op(8'h7F, 8'h01, 1'b0, "ovf pos");
    chk("ovf 7F+01", ovf, 1);
    chk("ovf 7F+01 sum", sum, 8'h80);
    do_op(8'hFF, 8'h01, 1'b0, "ovf neg");
    chk("ovf FF+01", ovf, 0);
    chk("ovf FF+01 cout", cout, 1);
`endif

    // Results hold while inputs toggle without start.
    hs = sum; hc = cout;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      @(posedge clk); #1;
      chk("hold sum", sum, hs);
      chk("hold cout", cout, hc);
      chk("hold done", done, 0);
    end

    // start held high: accepts every W+2 edges.
    for (int i = 0; i < 5 * P; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      start = 1'b1;
      if (i % P == 0) pend.push_back('{a, b, cin});
      @(posedge clk); #1;
      chk("held done", done, (i % P == W) ? 1 : 0);
      if (done && pend.size() > 0) begin
        op_t o;
        o = pend.pop_front();
        r = ref_add(o.a, o.b, o.cin);
        chk("held sum", sum, r[W-1:0]);
        chk("held cout", cout, r[W]);
      end
    end
    @(negedge clk);
    start = 1'b0;
    chk("held all done", pend.size(), 0);

    // Reset in the middle of RUN aborts the operation.
    do_op(8'h3C, 8'h0F, 1'b0, "pre-abort");
    @(negedge clk);
    a = 8'h55; b = 8'h22; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sum", sum, 0);
    chk("abort cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1;
    end
    chk("abort no done", seen, 0);
    do_op(8'h01, 8'h01, 1'b0, "post-abort");
    chk("post-abort sum", sum, 8'h02);

    for (int i = 0; i < 30; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom),
            $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
